// File: rtl/fpu_seq_multiplier_if.sv
// fpu_seq_multiplier_if: start/done handshake and operand/product bus for the sequential multiplier.
//  start           launch request from the requester
//  mulIn1, mulIn2  unsigned WIDTH-bit operands, latched on an accepted start
//  mulOut          2*WIDTH-bit product, valid while done=1
//  mulHi           upper WIDTH bits of mulOut
//  overflow        |mulHi, valid while done=1
//  busy            high while the product is being computed
//  done            level, high while a finished product is held
interface fpu_seq_multiplier_if #(parameter int WIDTH = 16);
    logic                   start;
    logic [WIDTH-1:0]       mulIn1;
    logic [WIDTH-1:0]       mulIn2;
    logic [2*WIDTH-1:0]     mulOut;
    logic [WIDTH-1:0]       mulHi;
    logic                   overflow;
    logic                   busy;
    logic                   done;
    modport master (output start, mulIn1, mulIn2, input mulOut, mulHi, overflow, busy, done);
    modport slave  (input start, mulIn1, mulIn2, output mulOut, mulHi, overflow, busy, done);
endinterface

// File: rtl/fpu_seq_multiplier.sv
// fpu_seq_multiplier: unsigned shift-and-add multiplier, one product bit per cycle, fixed WIDTH-cycle compute.
//  clock  rising-edge clock
//  reset  synchronous active-high reset; wins over a simultaneous start
//  bus    slave side of fpu_seq_multiplier_if (start, mulIn1, mulIn2 in; mulOut, mulHi, overflow, busy, done out)
//  FRACW is the operand fraction width; the product is not rescaled, the caller renormalises.
module fpu_seq_multiplier #(
    parameter int WIDTH = 16,
    parameter int FRACW = 10
) (
    input  logic                clock,
    input  logic                reset,
    fpu_seq_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    if (FRACW < 0 || FRACW > WIDTH) begin : gBadFracw
        $error("FRACW must lie within 0..WIDTH");
    end

    typedef enum logic [1:0] {MUL_WAIT = 2'd0, MUL_COMP = 2'd1, MUL_DONE = 2'd2} state_t;

    state_t           state;
    state_t           nextState;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   sum;
    logic             accept;

    assign accept = bus.start && (state == MUL_WAIT || state == MUL_DONE);
    // acc carries one guard bit so the partial sum never loses a carry.
    assign sum    = acc + (q[0] ? {1'b0, mcand} : '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= MUL_WAIT;
            counter <= '0;
            mcand   <= '0;
            acc     <= '0;
            q       <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                mcand   <= bus.mulIn1;
                acc     <= '0;
                q       <= bus.mulIn2;
                counter <= CW'(WIDTH);
            end else if (state == MUL_COMP) begin
                // Low product bits shift into q as the consumed multiplier bits shift out.
                {acc, q} <= {sum, q} >> 1;
                counter  <= counter - 1'b1;
            end
        end
    end

    always_comb begin
        nextState = MUL_WAIT;
        case (state)
            MUL_WAIT: nextState = bus.start ? MUL_COMP : MUL_WAIT;
            MUL_COMP: nextState = (counter == CW'(1)) ? MUL_DONE : MUL_COMP;
            MUL_DONE: nextState = bus.start ? MUL_COMP : MUL_DONE;
            default:  nextState = MUL_WAIT;
        endcase
    end

    assign bus.mulOut   = {acc[WIDTH-1:0], q};
    assign bus.mulHi    = acc[WIDTH-1:0];
    assign bus.overflow = |acc[WIDTH-1:0];
    assign bus.busy     = (state == MUL_COMP);
    assign bus.done     = (state == MUL_DONE);
endmodule

// File: tb/tb_fpu_seq_multiplier.sv
// tb_fpu_seq_multiplier: directed self-checking bench for fpu_seq_multiplier at WIDTH=16.
module tb_fpu_seq_multiplier;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    fpu_seq_multiplier_if #(.WIDTH(16)) bus ();

    fpu_seq_multiplier #(.WIDTH(16), .FRACW(10)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic runMul(input logic [15:0] a, input logic [15:0] b, output int cycles, output logic doneAfterStart);
        bus.mulIn1 = a;
        bus.mulIn2 = b;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.mulIn1 = 16'hDEAD;
        bus.mulIn2 = 16'hBEEF;
        doneAfterStart = bus.done;
        cycles = 0;
        while (bus.busy && cycles < 40) begin
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.mulIn1 = 16'h0003;
        bus.mulIn2 = 16'h0005;
        tick();
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.mulOut !== 32'h0) begin failures++; $display("FAIL reset_mulOut got=%h want=00000000", bus.mulOut); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
        reset = 1'b0;
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_basic();
        int   cyc;
        logic d0;
        runMul(16'd3, 16'd5, cyc, d0);
        checks++; if (cyc !== 16) begin failures++; $display("FAIL basic_latency got=%0d want=16", cyc); end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b want=1", bus.done); end
        checks++; if (bus.mulOut !== 32'h0000000F) begin failures++; $display("FAIL basic_mulOut got=%h want=0000000f", bus.mulOut); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%b want=0", bus.overflow); end
    endtask

    task automatic test_max();
        int   cyc;
        logic d0;
        int   bad;
        runMul(16'hFFFF, 16'hFFFF, cyc, d0);
        checks++; if (bus.mulOut !== 32'hFFFE0001) begin failures++; $display("FAIL max_mulOut got=%h want=fffe0001", bus.mulOut); end
        checks++; if (bus.mulHi !== 16'hFFFE) begin failures++; $display("FAIL max_mulHi got=%h want=fffe", bus.mulHi); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL max_overflow got=%b want=1", bus.overflow); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.mulOut !== 32'hFFFE0001 || bus.done !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL max_hold unstable_cycles got=%0d want=0", bad); end
    endtask

    task automatic test_zero();
        int   cyc;
        logic d0;
        runMul(16'h0000, 16'h1234, cyc, d0);
        checks++; if (cyc !== 16) begin failures++; $display("FAIL zero_a_latency got=%0d want=16", cyc); end
        checks++; if (bus.mulOut !== 32'h0) begin failures++; $display("FAIL zero_a_mulOut got=%h want=00000000", bus.mulOut); end
        runMul(16'h1234, 16'h0000, cyc, d0);
        checks++; if (cyc !== 16) begin failures++; $display("FAIL zero_b_latency got=%0d want=16", cyc); end
        checks++; if (bus.mulOut !== 32'h0) begin failures++; $display("FAIL zero_b_mulOut got=%h want=00000000", bus.mulOut); end
    endtask

    task automatic test_ignore_start();
        int notBusy;
        bus.mulIn1 = 16'h0100;
        bus.mulIn2 = 16'h0100;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        notBusy = 0;
        for (int i = 1; i < 16; i++) begin
            if (!bus.busy) notBusy++;
            bus.start  = (i == 5);
            bus.mulIn1 = (i == 5) ? 16'd7 : 16'hA5A5;
            bus.mulIn2 = (i == 5) ? 16'd7 : 16'h5A5A;
            tick();
        end
        bus.start = 1'b0;
        if (!bus.busy) notBusy++;
        tick();
        checks++; if (notBusy !== 0) begin failures++; $display("FAIL ignore_busy idle_cycles got=%0d want=0", notBusy); end
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL ignore_done got=%b want=1", bus.done); end
        checks++; if (bus.mulOut !== 32'h00010000) begin failures++; $display("FAIL ignore_mulOut got=%h want=00010000", bus.mulOut); end
    endtask

    task automatic test_abort();
        int   cyc;
        logic d0;
        bus.mulIn1 = 16'h1234;
        bus.mulIn2 = 16'h5678;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", bus.done); end
        checks++; if (bus.mulOut !== 32'h0) begin failures++; $display("FAIL abort_mulOut got=%h want=00000000", bus.mulOut); end
        runMul(16'h00FF, 16'h0101, cyc, d0);
        checks++; if (cyc !== 16) begin failures++; $display("FAIL abort_fresh_latency got=%0d want=16", cyc); end
        checks++; if (bus.mulOut !== 32'h0000FFFF) begin failures++; $display("FAIL abort_fresh_mulOut got=%h want=0000ffff", bus.mulOut); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL abort_fresh_overflow got=%b want=0", bus.overflow); end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic d0;
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL b2b_pre_done got=%b want=1", bus.done); end
        runMul(16'h8000, 16'h0002, cyc, d0);
        checks++; if (d0 !== 1'b0) begin failures++; $display("FAIL b2b_done_drop got=%b want=0", d0); end
        checks++; if (cyc !== 16) begin failures++; $display("FAIL b2b_latency got=%0d want=16", cyc); end
        checks++; if (bus.mulOut !== 32'h00010000) begin failures++; $display("FAIL b2b_mulOut got=%h want=00010000", bus.mulOut); end
        checks++; if (bus.mulHi !== 16'h0001) begin failures++; $display("FAIL b2b_mulHi got=%h want=0001", bus.mulHi); end
        checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL b2b_overflow got=%b want=1", bus.overflow); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.mulIn1 = '0;
        bus.mulIn2 = '0;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
